mul8_seq: RTL and testbench

Sequential 8x8 unsigned shift-and-add multiplier that drives an 8-bit ripple-carry adder stage and consumes its sum and carry-out. It computes one partial-product add per clock and retires a 16-bit product after 8 iterations. It sits directly upstream and downstream of the 8-bit adder: it feeds the adder's `a`, `b` and `cin` inputs and registers the adder's `sum` and `cout` outputs. It provides a start/busy/done handshake for a host controller.

---
 rtl/mul8_seq.sv | 141 ++++++++++++++
 tb/tb_mul8_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mul8_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier.
// One partial-product add per clock through an 8-bit ripple-carry adder
// (add_jl); the 16-bit product is retired after 8 iterations with a
// start/busy/done handshake towards the host.

// 8-bit ripple-carry adder used for the partial-product accumulation.
module add_jl (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] carry;

    assign carry[0] = cin;

    // One full-adder cell per bit, carry rippling from LSB to MSB.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_fa
            assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[8];

endmodule

module mul8_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] product,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  mcand_q, mcand_d;
    logic [15:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] product_q, product_d;

    logic [7:0]  add_b;
    logic [7:0]  add_sum;
    logic        add_cout;
    logic [15:0] acc_shifted;

    // The multiplier LSB selects whether the multiplicand is added this step.
    assign add_b = acc_q[0] ? mcand_q : 8'h00;

    add_jl u_add (
        .a    (acc_q[15:8]),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Carry-out lands in bit 15, so the 16-bit accumulator never overflows.
    assign acc_shifted = {add_cout, add_sum, acc_q[7:1]};

    // State and datapath registers; reset aborts any running operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= 8'h00;
            acc_q     <= 16'h0000;
            cnt_q     <= 3'd0;
            product_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Next-state logic: start is honoured only in IDLE, DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (cnt_q == 3'd7) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates: capture operands, iterate, and latch the final sum.
    always_comb begin
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d = a;
                    acc_d   = {8'h00, b};
                    cnt_d   = 3'd0;
                end
            end
            CALC: begin
                acc_d = acc_shifted;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    product_d = acc_shifted;
                end
            end
            default: begin
            end
        endcase
    end

    // Handshake outputs decoded purely from the registered state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            CALC:    busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
            end
        endcase
    end

    assign product = product_q;

endmodule

// File: tb/tb_mul8_seq.sv
// Bench for mul8_seq: directed cases plus randomized operands and stray
// start pulses, checked against a plain a*b reference with cycle timing
// derived from the accept edge.
module tb_mul8_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] product;
    logic        busy;
    logic        done;

    int n_cmp;
    int n_err;
    logic [15:0] held_product;

    mul8_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full operation. noise bit i (0..7) drives a stray start sampled at
    // iteration edge E(i+1); bit 8 drives a stray start sampled in DONE.
    task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic [8:0] noise);
        logic [15:0] exp_p;
        exp_p = 16'(x) * 16'(y);
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(negedge clk);                         // after accept edge E0
        start = 1'b0;
        a = $urandom_range(0, 255);             // must not disturb the operation
        b = $urandom_range(0, 255);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("busy_calc%0d", i), {15'd0, busy}, 16'd1);
            chk($sformatf("done_calc%0d", i), {15'd0, done}, 16'd0);
            chk($sformatf("hold_calc%0d", i), product, held_product);
            if (noise[i]) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        // now in the cycle after E8
        start = noise[8];
        if (noise[8]) begin
            a = 8'hFF; b = 8'hFF;
        end
        chk("done_pulse", {15'd0, done}, 16'd1);
        chk("busy_in_done", {15'd0, busy}, 16'd0);
        chk($sformatf("product_%h_%h", x, y), product, exp_p);
        @(negedge clk);                         // after E9: back in IDLE
        start = 1'b0;
        chk("done_after", {15'd0, done}, 16'd0);
        chk("busy_after", {15'd0, busy}, 16'd0);
        chk("product_hold", product, exp_p);
        held_product = exp_p;
        $display("op a=%h b=%h noise=%h product=%h expected=%h", x, y, noise, product, exp_p);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        held_product = 16'h0000;
        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
        #1;
        chk("rst_product", product, 16'h0000);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", {15'd0, busy}, 16'd0);

        // Directed operands
        do_op(8'h0F, 8'h0F, 9'h000);
        do_op(8'hFF, 8'hFF, 9'h000);
        do_op(8'h00, 8'hA5, 9'h000);
        do_op(8'hA5, 8'h00, 9'h000);
        do_op(8'h01, 8'h80, 9'h000);
        // Stray starts at iterations 3 and 8 and during DONE
        do_op(8'h12, 8'h34, 9'h184);
        @(negedge clk);
        chk("idle_after_noise_busy", {15'd0, busy}, 16'd0);
        chk("idle_after_noise_done", {15'd0, done}, 16'd0);

        // Asynchronous reset in the middle of iteration 4
        @(negedge clk);
        a = 8'hC8; b = 8'h03; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", {15'd0, busy}, 16'd0);
        chk("abort_done", {15'd0, done}, 16'd0);
        chk("abort_product", product, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        held_product = 16'h0000;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("post_abort_done%0d", i), {15'd0, done}, 16'd0);
            chk($sformatf("post_abort_busy%0d", i), {15'd0, busy}, 16'd0);
        end
        $display("abort a=c8 b=03 product=%h expected=0000", product);
        do_op(8'h07, 8'h09, 9'h000);

        // Back-to-back with start held high: accept every 10 cycles
        @(negedge clk);
        a = 8'h10; b = 8'h10; start = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);                     // after edge k relative to first accept
            chk($sformatf("b2b_busy%0d", k), {15'd0, busy}, {15'd0, ((k % 10) < 8)});
            chk($sformatf("b2b_done%0d", k), {15'd0, done}, {15'd0, ((k % 10) == 8)});
            if ((k % 10) == 8) begin
                chk($sformatf("b2b_product%0d", k), product, 16'h0100);
                $display("b2b cycle=%0d product=%h expected=0100", k, product);
            end
        end
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        held_product = 16'h0100;
        chk("b2b_idle_busy", {15'd0, busy}, 16'd0);

        // Randomized operands and stray start patterns
        for (int r = 0; r < 20; r++) begin
            logic [7:0] rx, ry;
            logic [8:0] rn;
            rx = 8'($urandom_range(0, 255));
            ry = 8'($urandom_range(0, 255));
            rn = (r % 2 == 0) ? 9'h000 : 9'($urandom_range(0, 511));
            do_op(rx, ry, rn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
